// File: rtl/hist_mem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the pixel loader (0) and histogram engine (1).
// Define ARB_BURST_EN to add lock0/lock1 burst locking, capped at MAX_BURST consecutive grants.
module hist_mem_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 128,
  parameter int MAX_BURST = 4
) (
  input  logic          wrclk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wd0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rd0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wd1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rd1,
`ifdef ARB_BURST_EN
  input  logic          lock0,
  input  logic          lock1,
`endif
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd,
  output logic          busy
);

  logic          ptr;
  logic          pick1;
  logic          vld_p1;
  logic          we_p1;
  logic          src_p1;
  logic [AW-1:0] addr_p1;
  logic [DW-1:0] wd_p1;

`ifdef ARB_BURST_EN
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_LIM = CW'(MAX_BURST);

  logic          last_gnt;
  logic [CW-1:0] burst_cnt;
`endif

  // Grant stage: pointer decides ties; a locked last winner may keep the grant until the cap.
  always_comb begin
    pick1 = ptr ? req1 : ~req0;
`ifdef ARB_BURST_EN
    if (burst_cnt < BURST_LIM) begin
      if (!last_gnt && lock0 && req0) begin
        pick1 = 1'b0;
      end else if (last_gnt && lock1 && req1) begin
        pick1 = 1'b1;
      end
    end
`endif
    gnt0 = rst_n & req0 & ~pick1;
    gnt1 = rst_n & req1 & pick1;
  end

`ifdef ARB_BURST_EN
  always_ff @(posedge wrclk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt  <= 1'b0;
      burst_cnt <= '0;
    end else if (gnt0 || gnt1) begin
      last_gnt  <= gnt1;
      burst_cnt <= (gnt1 == last_gnt && burst_cnt < BURST_LIM) ? burst_cnt + 1'b1 : CW'(1);
    end else begin
      burst_cnt <= '0;
    end
  end
`endif

  // Command stage (_p1): registered memory command plus the source tag of its issuer.
  always_ff @(posedge wrclk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= 1'b0;
      vld_p1  <= 1'b0;
      we_p1   <= 1'b0;
      src_p1  <= 1'b0;
      addr_p1 <= '0;
      wd_p1   <= '0;
    end else begin
      vld_p1 <= gnt0 | gnt1;
      src_p1 <= gnt1;
      if (gnt0) begin
        ptr     <= 1'b1;
        we_p1   <= we0;
        addr_p1 <= addr0;
        wd_p1   <= wd0;
      end else if (gnt1) begin
        ptr     <= 1'b0;
        we_p1   <= we1;
        addr_p1 <= addr1;
        wd_p1   <= wd1;
      end else begin
        we_p1   <= 1'b0;
      end
    end
  end

  assign mem_we   = we_p1;
  assign mem_addr = addr_p1;
  assign mem_wd   = wd_p1;

  // Return stage (_p2): capture memory data at the end of the read command cycle.
  always_ff @(posedge wrclk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rd0     <= '0;
      rd1     <= '0;
    end else begin
      rvalid0 <= vld_p1 & ~we_p1 & ~src_p1;
      rvalid1 <= vld_p1 & ~we_p1 & src_p1;
      if (vld_p1 && !we_p1 && !src_p1) begin
        rd0 <= mem_rd;
      end
      if (vld_p1 && !we_p1 && src_p1) begin
        rd1 <= mem_rd;
      end
    end
  end

  assign busy = vld_p1 | rvalid0 | rvalid1;

endmodule

// File: tb/tb_hist_mem_arbiter.sv
// Directed bench for hist_mem_arbiter with a combinational-read memory model.
// Define ARB_BURST_EN to build the lock ports and run the burst scenario.
module tb_hist_mem_arbiter;
  localparam int AW = 8;
  localparam int DW = 128;

  logic          wrclk = 1'b0;
  logic          rst_n;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wd0, wd1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rd0, rd1;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;
  logic          busy;
`ifdef ARB_BURST_EN
  logic          lock0, lock1;
`endif

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] mem [0:255];

  localparam logic [DW-1:0] W1  = 128'hffffffffffffffff0000000000000000;
  localparam logic [DW-1:0] P7E = {16{8'h7e}};
  localparam logic [DW-1:0] P81 = {16{8'h81}};
  localparam logic [DW-1:0] V   = 128'h0123456789abcdeffedcba9876543210;

  always #5 wrclk = ~wrclk;

  assign mem_rd = mem[mem_addr];
  always @(posedge wrclk) if (mem_we) mem[mem_addr] <= mem_wd;

  hist_mem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(4)) dut (
    .wrclk(wrclk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wd0(wd0), .gnt0(gnt0), .rvalid0(rvalid0), .rd0(rd0),
    .req1(req1), .we1(we1), .addr1(addr1), .wd1(wd1), .gnt1(gnt1), .rvalid1(rvalid1), .rd1(rd1),
`ifdef ARB_BURST_EN
    .lock0(lock0), .lock1(lock1),
`endif
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd), .busy(busy)
  );

  task automatic next();
    @(posedge wrclk);
    #1;
  endtask

  task automatic do_reset();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
`ifdef ARB_BURST_EN
    lock0 = 0; lock1 = 0;
`endif
    rst_n = 0;
    next();
    rst_n = 1;
  endtask

  task automatic test_reset();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; addr0 = 0; addr1 = 0; wd0 = 0; wd1 = 0;
`ifdef ARB_BURST_EN
    lock0 = 0; lock1 = 0;
`endif
    rst_n = 0;
    #2;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
    checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL rst_mem_addr got=%h exp=00", mem_addr); end
    checks++; if (mem_wd !== '0) begin errors++; $display("FAIL rst_mem_wd got=%h exp=0", mem_wd); end
    checks++; if ({gnt0, gnt1, rvalid0, rvalid1, busy} !== 5'b0) begin errors++; $display("FAIL rst_ctrl got=%b exp=00000", {gnt0, gnt1, rvalid0, rvalid1, busy}); end
    checks++; if (rd0 !== '0 || rd1 !== '0) begin errors++; $display("FAIL rst_rd got=%h/%h exp=0/0", rd0, rd1); end
    next();
    rst_n = 1;
  endtask

  task automatic test_write_read();
    req0 = 1; we0 = 1; addr0 = 8'h10; wd0 = W1;
    @(negedge wrclk);
    checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL wr_gnt got=%b%b exp=10", gnt0, gnt1); end
    next();
    we0 = 0;
    @(negedge wrclk);
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL rd_gnt0 got=%b exp=1", gnt0); end
    checks++; if (mem_we !== 1'b1 || mem_addr !== 8'h10 || mem_wd !== W1) begin errors++; $display("FAIL wr_cmd got=%b %h %h exp=1 10 %h", mem_we, mem_addr, mem_wd, W1); end
    next();
    req0 = 0;
    @(negedge wrclk);
    checks++; if (mem_we !== 1'b0 || mem_addr !== 8'h10 || rvalid0 !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL rd_cmd got=we%b a%h rv%b busy%b exp=we0 a10 rv0 busy1", mem_we, mem_addr, rvalid0, busy); end
    next();
    @(negedge wrclk);
    checks++; if (rvalid0 !== 1'b1 || rd0 !== W1) begin errors++; $display("FAIL wr_rd_data got=%b %h exp=1 %h", rvalid0, rd0, W1); end
    checks++; if (rvalid1 !== 1'b0) begin errors++; $display("FAIL wr_rd_rv1 got=%b exp=0", rvalid1); end
    next();
    @(negedge wrclk);
    checks++; if (rvalid0 !== 1'b0) begin errors++; $display("FAIL wr_rd_pulse got=%b exp=0", rvalid0); end
  endtask

  task automatic test_contention();
    do_reset();
    we0 = 0; we1 = 0; addr0 = 8'h20; addr1 = 8'h21; req0 = 1; req1 = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge wrclk);
      checks++; if (gnt0 !== (i % 2 == 0) || gnt1 !== (i % 2 == 1)) begin errors++; $display("FAIL rr_gnt[%0d] got=%b%b exp=%b%b", i, gnt0, gnt1, (i % 2 == 0), (i % 2 == 1)); end
      if (i > 0) begin
        checks++; if (mem_addr !== ((i % 2 == 1) ? 8'h20 : 8'h21)) begin errors++; $display("FAIL rr_addr[%0d] got=%h exp=%h", i, mem_addr, (i % 2 == 1) ? 8'h20 : 8'h21); end
      end
      next();
    end
    req0 = 0; req1 = 0;
    @(negedge wrclk);
    checks++; if (mem_addr !== 8'h21) begin errors++; $display("FAIL rr_addr_last got=%h exp=21", mem_addr); end
    next(); next(); next();
  endtask

  task automatic test_interleaved();
    req0 = 1; we0 = 0; addr0 = 8'h01;
    @(negedge wrclk);
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL il_gnt0 got=%b exp=1", gnt0); end
    next();
    req0 = 0; req1 = 1; we1 = 0; addr1 = 8'h02;
    @(negedge wrclk);
    checks++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin errors++; $display("FAIL il_gnt1 got=%b%b exp=01", gnt0, gnt1); end
    next();
    req1 = 0;
    @(negedge wrclk);
    checks++; if (rvalid0 !== 1'b1 || rd0 !== P7E || rvalid1 !== 1'b0) begin errors++; $display("FAIL il_ret0 got=%b %h rv1=%b exp=1 %h rv1=0", rvalid0, rd0, rvalid1, P7E); end
    checks++; if (mem_addr !== 8'h02) begin errors++; $display("FAIL il_addr1 got=%h exp=02", mem_addr); end
    next();
    @(negedge wrclk);
    checks++; if (rvalid1 !== 1'b1 || rd1 !== P81 || rvalid0 !== 1'b0) begin errors++; $display("FAIL il_ret1 got=%b %h rv0=%b exp=1 %h rv0=0", rvalid1, rd1, rvalid0, P81); end
    next();
    @(negedge wrclk);
    checks++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL il_idle got=%b%b busy%b exp=00 busy0", rvalid0, rvalid1, busy); end
  endtask

  task automatic test_back_to_back();
    req0 = 1; we0 = 1; addr0 = 8'h30; wd0 = V;
    @(negedge wrclk);
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL raw_gnt_w got=%b exp=1", gnt0); end
    next();
    we0 = 0;
    @(negedge wrclk);
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL raw_gnt_r got=%b exp=1", gnt0); end
    next();
    req0 = 0;
    @(negedge wrclk);
    checks++; if (mem_we !== 1'b0 || mem_addr !== 8'h30) begin errors++; $display("FAIL raw_rcmd got=%b %h exp=0 30", mem_we, mem_addr); end
    next();
    @(negedge wrclk);
    checks++; if (rvalid0 !== 1'b1 || rd0 !== V) begin errors++; $display("FAIL raw_data got=%b %h exp=1 %h", rvalid0, rd0, V); end
    next();
  endtask

  task automatic test_reset_mid_read();
    req0 = 1; we0 = 0; addr0 = 8'h01;
    @(negedge wrclk);
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL mr_gnt got=%b exp=1", gnt0); end
    next();
    req0 = 1; req1 = 1; we0 = 1; we1 = 1; addr0 = 8'h50; addr1 = 8'h51;
    rst_n = 0;
    #1;
    checks++; if ({gnt0, gnt1, rvalid0, rvalid1, mem_we, busy} !== 6'b0) begin errors++; $display("FAIL mr_ctrl got=%b exp=000000", {gnt0, gnt1, rvalid0, rvalid1, mem_we, busy}); end
    checks++; if (mem_addr !== 8'h00 || rd0 !== '0) begin errors++; $display("FAIL mr_data got=%h %h exp=00 0", mem_addr, rd0); end
    next();
    rst_n = 1;
    @(negedge wrclk);
    checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || rvalid0 !== 1'b0) begin errors++; $display("FAIL mr_first got=%b%b rv0=%b exp=10 rv0=0", gnt0, gnt1, rvalid0); end
    next();
    req0 = 0; req1 = 0;
    @(negedge wrclk);
    checks++; if (rvalid0 !== 1'b0) begin errors++; $display("FAIL mr_norv_a got=%b exp=0", rvalid0); end
    next();
    @(negedge wrclk);
    checks++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin errors++; $display("FAIL mr_norv_b got=%b%b exp=00", rvalid0, rvalid1); end
    next(); next();
  endtask

  task automatic test_abandoned();
    do_reset();
    req0 = 1; we0 = 1; addr0 = 8'h40; wd0 = P7E;
    req1 = 1; we1 = 1; addr1 = 8'h41; wd1 = P81;
    @(negedge wrclk);
    checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL ab_gnt got=%b%b exp=10", gnt0, gnt1); end
    next();
    req0 = 0; req1 = 0;
    @(negedge wrclk);
    checks++; if (mem_we !== 1'b1 || mem_addr !== 8'h40 || busy !== 1'b1) begin errors++; $display("FAIL ab_cmd got=%b %h busy%b exp=1 40 busy1", mem_we, mem_addr, busy); end
    next();
    @(negedge wrclk);
    checks++; if (busy !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL ab_idle got=busy%b we%b exp=busy0 we0", busy, mem_we); end
    next();
    @(negedge wrclk);
    checks++; if (mem_we !== 1'b0 || mem_addr !== 8'h40) begin errors++; $display("FAIL ab_never got=%b %h exp=0 40", mem_we, mem_addr); end
  endtask

`ifdef ARB_BURST_EN
  task automatic test_burst();
    logic [9:0] pat;
    pat = 10'b1000010000;
    do_reset();
    lock0 = 1; req0 = 1; req1 = 1; we0 = 1; we1 = 1; addr0 = 8'h60; addr1 = 8'h61;
    for (int i = 0; i < 10; i++) begin
      @(negedge wrclk);
      checks++; if (gnt1 !== pat[i] || gnt0 !== ~pat[i]) begin errors++; $display("FAIL burst[%0d] got=%b%b exp=%b%b", i, gnt0, gnt1, ~pat[i], pat[i]); end
      next();
    end
    req0 = 0; req1 = 0; lock0 = 0;
    next(); next();
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[1] = P7E;
    mem[2] = P81;
    test_reset();
    test_write_read();
    test_contention();
    test_interleaved();
    test_back_to_back();
    test_reset_mid_read();
    test_abandoned();
`ifdef ARB_BURST_EN
    test_burst();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hist_mem_arbiter.md
Name: hist_mem_arbiter

Overview:
Two-requester round-robin arbiter that shares the single-port 128-bit data memory between the pixel loader (requester 0) and the histogram engine (requester 1). It accepts one read or write command per cycle and drives registered commands to the memory. It returns read data to the requester that issued the read, with fixed latency.

Parameters:
AW, 8, memory word address width
DW, 128, data width (16 packed pixel bytes per word)
MAX_BURST, 4, maximum consecutive grants under lock (used only with the optional feature)

Ports:
wrclk  in  1  clock, all logic on rising edge
rst_n  in  1  reset, asynchronous, active-low
req0  in  1  requester 0 command valid, held until gnt0
we0  in  1  requester 0: 1 = write, 0 = read
addr0  in  AW  requester 0 address
wd0  in  DW  requester 0 write data
gnt0  out  1  requester 0 command accepted this cycle (combinational)
rvalid0  out  1  requester 0 read data valid
rd0  out  DW  requester 0 read data
req1, we1, addr1, wd1, gnt1, rvalid1, rd1  same as above, for requester 1
lock0, lock1  in  1  burst lock request (present only with ARB_BURST_EN)
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wd  out  DW  memory write data
mem_rd  in  DW  memory read data, valid the cycle after the command
busy  out  1  command or read in flight

Behaviour:
- Reset (rst_n=0, async): gnt*=0, rvalid*=0, rd*=0, mem_we=0, mem_addr=0, mem_wd=0, busy=0. The priority pointer favours requester 0. Any in-flight read is discarded and no rvalid pulse follows.
- Acceptance: a command is accepted at edge T when reqN=1 and gntN=1 in the cycle before T.
- At most one gnt is high per cycle. gnt is low for both requesters when neither is requesting.
- Round-robin:
  - Only one requester asserting req: that requester is granted.
  - Both asserting req: the requester the pointer favours is granted.
  - After every grant, the pointer moves to favour the other requester.
- Command stage: in cycle T+1, registers drive mem_we=weN, mem_addr=addrN, mem_wd=wdN. With no acceptance, mem_we is forced to 0 and addr/wd hold their last values.
- Read return: the command stage carries a source tag. For a read issued in T+1, mem_rd is captured at the end of T+1. rdN=captured data and rvalidN=1 for exactly the one cycle T+2. The other requester's rvalid stays 0. Read latency is 2 cycles from acceptance.
- Writes generate no rvalid.
- Back-to-back: a new command can be accepted every cycle. Reads and writes may interleave freely. Read returns come back in issue order.
- Read-after-write to the same address on consecutive accepts: the memory is written at the end of T+1. The following read's command is in T+2, so it returns the new data.
- busy = any valid command stage or read-return stage.
- Requester protocol: weN, addrN and wdN stay stable while reqN=1 and gntN=0. Dropping req before grant is legal; the command is then abandoned and never issued.

Optional Feature:
Macro ARB_BURST_EN.
- Defined:
  - If the last-granted requester has lockN=1 and reqN=1, it keeps the grant regardless of the pointer, for up to MAX_BURST consecutive grants.
  - A burst counter is cleared on reset, on any grant to the other requester, and on any cycle without a grant.
  - When the counter reaches MAX_BURST, the other requester wins if it is requesting. If it is not requesting, the counter restarts.
- Undefined: the lock0/lock1 ports do not exist, and arbitration is pure round-robin.

Test Plan:
1. Write then read, requester 0: write addr0=8'h10, wd0=128'hffffffffffffffff0000000000000000, then read 8'h10 -> rvalid0 exactly 2 cycles after the read grant, rd0 equals the written value, rvalid1 stays 0.
2. Contention: req0 and req1 held high for 6 cycles after reset -> grants alternate 0,1,0,1,0,1, and mem_addr follows the granted addresses one cycle later.
3. Interleaved reads: requester 0 reads 8'h01 (7e7e7e...), requester 1 reads 8'h02 (818181...) on consecutive cycles -> rvalid0 with 7e7e7e... then rvalid1 with 818181..., each a single cycle.
4. Reset mid-read: rst_n pulsed low the cycle after a read is accepted -> all outputs 0 immediately, no rvalid afterwards, and the first grant after release goes to requester 0 when both request.
5. Idle and abandoned request: req1 raised for one cycle while requester 0 holds the grant, then dropped -> mem_we never asserts for requester 1's command, and busy returns to 0 two cycles after the last grant.
6. With ARB_BURST_EN: lock0=1 and req0/req1 both high for 10 cycles, MAX_BURST=4 -> grant pattern 0,0,0,0,1,0,0,0,0,1.
